alu_sequencer: RTL and testbench

- Multi-cycle control sequencer on the driving side of the ALU control/flag interface.
- Accepts one 32-bit instruction per handshake and decodes it.
- Drives register-file read indices, the ALU operand and control selects (ALUimm, ALUfn, logicfn, fnClass) and the sign-extended immediate.
- Captures the ALU result and flags, writes the result back or resolves a flag-conditioned branch.
- Sits between instruction fetch and the register file/ALU datapath.

---
 rtl/alu_sequencer.sv | 92 +++++++++
 tb/tb_alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state instruction sequencer driving ALU controls, write-back and flag-based branches
module alu_sequencer #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    input  logic [DW-1:0]  instr,
    output logic           instr_ready,
    output logic [RAW-1:0] rs_idx,
    output logic [RAW-1:0] rt_idx,
    output logic [DW-1:0]  imm,
    output logic           ALUimm,
    output logic           ALUfn,
    output logic           logicfn,
    output logic           fnClass,
    input  logic [DW-1:0]  alu_result,
    input  logic           zFlag,
    input  logic           carryFlag,
    input  logic           signFlag,
    input  logic           overflowFlag,
    output logic           rf_we,
    output logic [RAW-1:0] rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic           br_valid,
    output logic           br_taken,
    output logic [DW-1:0]  br_offset,
    output logic           illegal,
    output logic [3:0]     flags_q,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    state_t state, next;
    logic [DW-1:0] instr_q;
    logic [5:0] op;
    logic [2:0] fn;
    logic is_alu, is_arith, is_br, is_ill, ctl_en, wb, br_cond;
    logic [RAW-1:0] dest;
    logic [DW-1:0] sext;
    assign op = instr_q[31:26];
    assign fn = op[2:0];
    // 0x01-0x04 are R-type, 0x09-0x0C the same functions with the immediate (bit 3)
    assign is_alu = op[5:4] == 2'b00 && fn >= 3'd1 && fn <= 3'd4;
    assign is_arith = is_alu && fn <= 3'd2;
    assign is_br = op >= 6'h10 && op <= 6'h14;
    assign is_ill = !(is_alu || is_br || op == 6'h00);
    assign dest = op[3] ? instr_q[20:16] : instr_q[15:11];
    assign sext = {{(DW-16){instr_q[15]}}, instr_q[15:0]};
    assign br_cond = fn == 3'd0 ? flags_q[3] : fn == 3'd1 ? !flags_q[3] :
                     fn == 3'd2 ? flags_q[2] : fn == 3'd3 ? flags_q[1] : flags_q[0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state == IDLE ? (instr_valid ? DECODE : IDLE) :
               state == DECODE ? EXEC : state == EXEC ? WB : IDLE;
    end
    always_comb begin
        ctl_en = state == DECODE || state == EXEC;
        wb = state == WB;
        instr_ready = state == IDLE;
        busy = state != IDLE;
        rs_idx = ctl_en ? instr_q[25:21] : '0;
        rt_idx = ctl_en ? instr_q[20:16] : '0;
        imm = ctl_en ? sext : '0;
        ALUimm = ctl_en && is_alu && op[3];
        ALUfn = ctl_en && is_alu && fn == 3'd2;
        logicfn = ctl_en && is_alu && fn == 3'd4;
        fnClass = ctl_en && is_alu && fn >= 3'd3;
        rf_we = wb && is_alu && dest != '0;
        rf_waddr = wb && is_alu ? dest : '0;
        br_valid = wb && is_br;
        br_taken = wb && is_br && br_cond;
        br_offset = wb && is_br ? sext : '0;
        illegal = wb && is_ill;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            rf_wdata <= '0;
            flags_q <= '0;
        end else begin
            if (state == IDLE && instr_valid) instr_q <= instr;
            if (state == EXEC) begin
                rf_wdata <= alu_result;
                if (is_arith) flags_q <= {zFlag, carryFlag, signFlag, overflowFlag};
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench with an instruction-level reference model
module tb_alu_sequencer;
    logic clk = 0, rst = 1;
    logic instr_valid = 0;
    logic [31:0] instr = 0;
    logic instr_ready, ALUimm, ALUfn, logicfn, fnClass;
    logic [4:0] rs_idx, rt_idx, rf_waddr;
    logic [31:0] imm, alu_result, rf_wdata, br_offset;
    logic zFlag, carryFlag, signFlag, overflowFlag;
    logic rf_we, br_valid, br_taken, illegal, busy;
    logic [3:0] flags_q;

    always #5 clk = ~clk;

    alu_sequencer #(.DW(32), .RAW(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .imm(imm), .ALUimm(ALUimm), .ALUfn(ALUfn),
        .logicfn(logicfn), .fnClass(fnClass), .alu_result(alu_result), .zFlag(zFlag),
        .carryFlag(carryFlag), .signFlag(signFlag), .overflowFlag(overflowFlag), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .br_valid(br_valid), .br_taken(br_taken),
        .br_offset(br_offset), .illegal(illegal), .flags_q(flags_q), .busy(busy)
    );

    typedef struct {
        logic [31:0] imm, wdata, boff;
        logic [4:0] rs, rt, waddr;
        logic [3:0] ctl, fl;
        logic alu, we, bv, bt, ill;
        int acc;
    } exp_t;

    logic [31:0] rf [32];
    logic [3:0] ref_fl = 0;
    int cyc = 0, last_acc = -1;
    int vectors = 0, miscompares = 0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ALU flag definition shared by the environment ALU and the reference model: {z,c,s,v,result}
    function automatic logic [35:0] arith(input logic [31:0] a, input logic [31:0] b, input logic neg);
        logic [32:0] s;
        logic v;
        s = neg ? 33'd0 - {1'b0, b} : {1'b0, a} + {1'b0, b};
        v = neg ? (b == 32'h8000_0000) : (a[31] == b[31]) && (s[31] != a[31]);
        return {s[31:0] == 32'd0, s[32], s[31], v, s[31:0]};
    endfunction

    // Environment ALU: reacts to whatever controls the sequencer drives
    logic [31:0] alu_a, alu_b;
    logic [35:0] alu_f;
    always_comb begin
        alu_a = rf[rs_idx];
        alu_b = ALUimm ? imm : rf[rt_idx];
        alu_f = arith(alu_a, alu_b, ALUfn);
        alu_result = alu_f[31:0];
        {zFlag, carryFlag, signFlag, overflowFlag} = alu_f[35:32];
        if (fnClass) begin
            alu_result = logicfn ? (alu_a | alu_b) : (alu_a & alu_b);
            {zFlag, carryFlag, signFlag, overflowFlag} = {alu_result == 32'd0, 1'b1, alu_result[31], 1'b1};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] i16);
        return {op, rs, rt, i16};
    endfunction

    // Instruction-level reference: what each opcode must do, by mnemonic
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [31:0] a, b, sx, res;
        logic [35:0] f;
        logic [4:0] dst;
        logic arith_op;
        e = '{default: 0};
        sx = {{16{w[15]}}, w[15:0]};
        a = rf[w[25:21]];
        e.rs = w[25:21];
        e.rt = w[20:16];
        e.imm = sx;
        arith_op = 0;
        res = 0;
        dst = w[15:11];
        b = rf[w[20:16]];
        case (w[31:26])
            6'h01: begin e.alu = 1; arith_op = 1; f = arith(a, b, 0); e.ctl = 4'b0000; end
            6'h02: begin e.alu = 1; arith_op = 1; f = arith(a, b, 1); e.ctl = 4'b0100; end
            6'h03: begin e.alu = 1; res = a & b; e.ctl = 4'b0001; end
            6'h04: begin e.alu = 1; res = a | b; e.ctl = 4'b0011; end
            6'h09: begin e.alu = 1; arith_op = 1; f = arith(a, sx, 0); e.ctl = 4'b1000; dst = w[20:16]; end
            6'h0A: begin e.alu = 1; arith_op = 1; f = arith(a, sx, 1); e.ctl = 4'b1100; dst = w[20:16]; end
            6'h0B: begin e.alu = 1; res = a & sx; e.ctl = 4'b1001; dst = w[20:16]; end
            6'h0C: begin e.alu = 1; res = a | sx; e.ctl = 4'b1011; dst = w[20:16]; end
            6'h10: begin e.bv = 1; e.bt = ref_fl[3]; end
            6'h11: begin e.bv = 1; e.bt = !ref_fl[3]; end
            6'h12: begin e.bv = 1; e.bt = ref_fl[2]; end
            6'h13: begin e.bv = 1; e.bt = ref_fl[1]; end
            6'h14: begin e.bv = 1; e.bt = ref_fl[0]; end
            6'h00: ;
            default: e.ill = 1;
        endcase
        if (arith_op) begin
            res = f[31:0];
            ref_fl = f[35:32];
        end
        e.we = e.alu && dst != 5'd0;
        e.waddr = dst;
        e.wdata = res;
        e.boff = sx;
        e.fl = ref_fl;
        return e;
    endfunction

    // Monitor: checks controls on the first busy cycle and strobes on the last busy cycle
    logic pb = 0, p_we, p_bv, p_bt, p_ill;
    logic [4:0] p_waddr;
    logic [31:0] p_wdata, p_boff;
    logic [3:0] p_fl;
    int p_cyc, pulses = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            pb = 0;
            pulses = 0;
        end else begin
            if (busy && !pb) begin
                pulses = 0;
                if (q.size() == 0) chk("spurious_start", 1, 0);
                else begin
                    e = q[0];
                    chk("rs_idx", rs_idx, e.rs);
                    chk("rt_idx", rt_idx, e.rt);
                    chk("imm", imm, e.imm);
                    if (e.alu) chk("alu_ctl", {ALUimm, ALUfn, logicfn, fnClass}, e.ctl);
                    chk("decode_lat", cyc - e.acc, 1);
                end
            end
            if (!busy && pb) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rf_we", p_we, e.we);
                    if (e.we) begin
                        chk("rf_waddr", p_waddr, e.waddr);
                        chk("rf_wdata", p_wdata, e.wdata);
                    end
                    chk("br_valid", p_bv, e.bv);
                    if (e.bv) begin
                        chk("br_taken", p_bt, e.bt);
                        chk("br_offset", p_boff, e.boff);
                    end
                    chk("illegal", p_ill, e.ill);
                    chk("flags_q", p_fl, e.fl);
                    chk("wb_lat", p_cyc - e.acc, 3);
                    chk("pulse_cnt", pulses, (e.we || e.bv || e.ill) ? 1 : 0);
                end
            end
            if (rf_we || br_valid || illegal) pulses++;
            pb = busy;
            p_we = rf_we; p_bv = br_valid; p_bt = br_taken; p_ill = illegal;
            p_waddr = rf_waddr; p_wdata = rf_wdata; p_boff = br_offset; p_fl = flags_q;
            p_cyc = cyc;
        end
    end

    // hold=1 keeps instr_valid high the whole time, with junk words while busy
    task automatic issue(input logic [31:0] w, input bit hold);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            instr = $urandom;
            instr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        instr = w;
        instr_valid = 1;
        e = model(w);
        e.acc = cyc;
        if (hold && last_acc >= 0) chk("throughput", cyc - last_acc, 4);
        last_acc = hold ? cyc : -1;
        q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        logic [5:0] ops [14];
        logic [5:0] op;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h10, 6'h11, 6'h12, 6'h13, 6'h14};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 0; rf[1] = 2; rf[2] = 3; rf[4] = 1; rf[5] = 1; rf[7] = 5; rf[8] = 32'hFFFF_FFFB;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_strobes", {rf_we, br_valid, illegal}, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_ctl", {ALUimm, ALUfn, logicfn, fnClass, imm}, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", instr_ready, 1);

        issue(rtype(6'h01, 1, 2, 3), 1);
        issue(itype(6'h09, 4, 6, 16'hFFFF), 1);
        issue(rtype(6'h02, 0, 5, 9), 1);
        issue(itype(6'h11, 0, 0, 16'h0010), 1);
        issue(rtype(6'h01, 7, 8, 10), 1);
        issue(rtype(6'h03, 1, 2, 11), 1);
        issue(itype(6'h10, 0, 0, 16'h8004), 1);
        issue(32'hFC00_0000 | 32'($urandom_range(0, 32'h03FF_FFFF)), 1);
        issue(rtype(6'h01, 1, 2, 0), 1);
        issue(itype(6'h0A, 3, 12, 16'h0001), 1);

        // Abort in EXEC after flags are known to be non-zero
        issue(rtype(6'h01, 1, 2, 13), 1);
        @(negedge clk);
        instr_valid = 0;
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_flags", flags_q, 0);
        chk("abort_strobes", {rf_we, br_valid, illegal}, 0);
        chk("abort_wdata", rf_wdata, 0);
        ref_fl = 0;
        @(posedge clk);
        #2 rst = 0;
        last_acc = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_idle", {instr_ready, busy, rf_we, br_valid, illegal}, 5'b10000);
        end

        for (int i = 0; i < 160; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                instr_valid = 0;
            end
            issue({op, 26'($urandom)}, 0);
        end
        @(negedge clk);
        instr_valid = 0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
